// File: rtl/dt_frame_sequencer.sv
// Frame sequencer for the double-threshold stage: forwards pixels, drains the window, latches thresholds.
// Optional THRESH_OVERRIDE_EN adds cfg_override/cfg_h_t/cfg_l_t to replace the computed thresholds.
module dt_frame_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned FLUSH_CYCLES = 639
) (
    input  logic                  clock,
    input  logic                  rst_n,
`ifdef THRESH_OVERRIDE_EN
    input  logic                  cfg_override,
    input  logic [DATA_WIDTH-1:0] cfg_h_t,
    input  logic [DATA_WIDTH-1:0] cfg_l_t,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sof,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [DATA_WIDTH-1:0] h_t,
    output logic [DATA_WIDTH-1:0] l_t,
    output logic [DATA_WIDTH-1:0] frame_max,
    output logic                  frame_done,
    output logic                  err_sof
);

    localparam int unsigned COL_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned FL_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam bit          NO_FLUSH = (FLUSH_CYCLES == 0);

    localparam logic [DATA_WIDTH-1:0] DIV_TEN = DATA_WIDTH'(10);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [1:0]            state, state_n;
    logic [COL_W-1:0]      col, col_n, pos_col;
    logic [ROW_W-1:0]      row, row_n, pos_row;
    logic [FL_W-1:0]       fl_cnt, fl_cnt_n;
    logic [DATA_WIDTH-1:0] run_max, run_max_n;
    logic [DATA_WIDTH-1:0] h_calc, l_calc;
    logic                  m_valid_n, frame_done_n, err_sof_n;
    logic [DATA_WIDTH-1:0] m_data_n, h_t_n, l_t_n, frame_max_n;
    logic                  accept, line_end, frame_end;

    assign s_ready = (state == S_IDLE) || (state == S_ACTIVE);
    assign accept  = s_valid && s_ready;

    // A sof accept always counts as pixel (0,0), whether starting or restarting a frame.
    assign pos_col   = s_sof ? '0 : col;
    assign pos_row   = s_sof ? '0 : row;
    assign line_end  = (pos_col == COL_W'(IMG_WIDTH - 1));
    assign frame_end = line_end && (pos_row == ROW_W'(IMG_HEIGHT - 1));

    assign h_calc = run_max / DIV_TEN;
    assign l_calc = h_calc >> 1;

    // Next-state and registered-output decode
    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        fl_cnt_n     = fl_cnt;
        run_max_n    = run_max;
        m_valid_n    = 1'b0;
        m_data_n     = '0;
        frame_done_n = 1'b0;
        err_sof_n    = 1'b0;
        h_t_n        = h_t;
        l_t_n        = l_t;
        frame_max_n  = frame_max;
        case (state)
            S_IDLE, S_ACTIVE: begin
                if (accept && (s_sof || (state == S_ACTIVE))) begin
                    m_valid_n = 1'b1;
                    m_data_n  = s_data;
                    err_sof_n = s_sof && (state == S_ACTIVE);
                    run_max_n = (s_sof || (s_data > run_max)) ? s_data : run_max;
                    if (frame_end) begin
                        col_n    = '0;
                        row_n    = '0;
                        fl_cnt_n = '0;
                        state_n  = NO_FLUSH ? S_UPDATE : S_FLUSH;
                    end else begin
                        col_n   = line_end ? '0 : pos_col + COL_W'(1);
                        row_n   = line_end ? pos_row + ROW_W'(1) : pos_row;
                        state_n = S_ACTIVE;
                    end
                end
            end
            S_FLUSH: begin
                m_valid_n = 1'b1;
                if (fl_cnt == FL_W'(FL_LAST)) begin
                    state_n = S_UPDATE;
                end else begin
                    fl_cnt_n = fl_cnt + FL_W'(1);
                end
            end
            S_UPDATE: begin
                frame_done_n = 1'b1;
                frame_max_n  = run_max;
`ifdef THRESH_OVERRIDE_EN
                h_t_n = cfg_override ? cfg_h_t : h_calc;
                l_t_n = cfg_override ? cfg_l_t : l_calc;
`else
                h_t_n = h_calc;
                l_t_n = l_calc;
`endif
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            fl_cnt     <= '0;
            run_max    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            h_t        <= '1;
            l_t        <= '1;
            frame_max  <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            fl_cnt     <= fl_cnt_n;
            run_max    <= run_max_n;
            m_valid    <= m_valid_n;
            m_data     <= m_data_n;
            frame_done <= frame_done_n;
            err_sof    <= err_sof_n;
            h_t        <= h_t_n;
            l_t        <= l_t_n;
            frame_max  <= frame_max_n;
        end
    end

endmodule

// File: tb/tb_dt_frame_sequencer.sv
// Scoreboard bench for dt_frame_sequencer with a 4x2 frame and 3 flush cycles.
module tb_dt_frame_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned F  = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } exp_pix_t;

    typedef struct packed {
        logic [DW-1:0] h;
        logic [DW-1:0] l;
        logic [DW-1:0] fm;
    } exp_thr_t;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sof = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] h_t, l_t, frame_max;
    logic          frame_done, err_sof;
`ifdef THRESH_OVERRIDE_EN
    logic          cfg_override = 1'b0;
    logic [DW-1:0] cfg_h_t = '0;
    logic [DW-1:0] cfg_l_t = '0;
`endif

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    exp_pix_t exp_q[$];
    exp_thr_t thr_q[$];
    logic prev_last = 1'b0;

    always #5 clock = ~clock;

    dt_frame_sequencer #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_CYCLES(F)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
`ifdef THRESH_OVERRIDE_EN
        .cfg_override(cfg_override),
        .cfg_h_t(cfg_h_t),
        .cfg_l_t(cfg_l_t),
`endif
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_sof(s_sof),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_data(m_data),
        .h_t(h_t),
        .l_t(l_t),
        .frame_max(frame_max),
        .frame_done(frame_done),
        .err_sof(err_sof)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data or a frame_done
    always @(negedge clock) begin
        exp_pix_t ep;
        exp_thr_t et;
        logic cur_last;
        cur_last = 1'b0;
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_m_valid actual=%0d expected=none at %0t", m_data, $time);
            end else begin
                ep = exp_q.pop_front();
                chk("m_data", int'(m_data), int'(ep.d));
                cur_last = ep.last;
            end
        end
        if (frame_done) begin
            chk("frame_done_after_flush", int'(prev_last), 1);
            chk("m_valid_in_done_cycle", int'(m_valid), 0);
            if (thr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done actual=1 expected=0 at %0t", $time);
            end else begin
                et = thr_q.pop_front();
                chk("h_t", int'(h_t), int'(et.h));
                chk("l_t", int'(l_t), int'(et.l));
                chk("frame_max", int'(frame_max), int'(et.fm));
            end
        end
        if (err_sof) err_seen++;
        prev_last = cur_last;
    end

    // Drive one pixel; waits (bounded) for s_ready and reports the cycles spent stalled
    task automatic send(input logic [DW-1:0] d, input logic sof, input logic fwd,
                        input logic last_frame, output int stalls);
        stalls = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && stalls < 50) begin
            @(posedge clock);
            #1;
            stalls++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout actual=0 expected=1 at %0t", $time);
        end
        if (fwd) exp_q.push_back('{d: d, last: 1'b0});
        if (last_frame) begin
            for (int i = 0; i < int'(F); i++)
                exp_q.push_back('{d: '0, last: (i == int'(F) - 1)});
        end
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || thr_q.size() != 0) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_timeout", n < 100 ? 1 : 0, 1);
    endtask

    initial begin
        logic [DW-1:0] fa[8];
        int st;
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pix[8];
        int st;

        // Reset held 3 cycles
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        chk("rst_h_t", int'(h_t), 255);
        chk("rst_l_t", int'(l_t), 255);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_max", int'(frame_max), 0);

        // Frame with max 200 -> h_t=20, l_t=10
        pix = '{8'd10, 8'd20, 8'd30, 8'd200, 8'd40, 8'd50, 8'd60, 8'd70};
        thr_q.push_back('{h: 8'd20, l: 8'd10, fm: 8'd200});
        for (int i = 0; i < 8; i++)
            send(pix[i], i == 0, 1'b1, i == 7, st);
        wait_idle();

        // Pixels without sof while idle are dropped
        for (int i = 0; i < 3; i++)
            send(8'(i + 99), 1'b0, 1'b0, 1'b0, st);
        repeat (3) @(posedge clock);
        #1;
        chk("idle_drop_h_t", int'(h_t), 20);
        chk("idle_drop_l_t", int'(l_t), 10);

        // sof on 5th pixel restarts the frame; max 90 -> 9/4
        pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        for (int i = 0; i < 4; i++)
            send(pix[i], i == 0, 1'b1, 1'b0, st);
        thr_q.push_back('{h: 8'd9, l: 8'd4, fm: 8'd90});
        send(8'd90, 1'b1, 1'b1, 1'b0, st);
        for (int i = 0; i < 7; i++)
            send(pix[i], 1'b0, 1'b1, i == 6, st);

        // Next pixel held through FLUSH/UPDATE; frame max 255
`ifdef THRESH_OVERRIDE_EN
        cfg_override = 1'b1;
        cfg_h_t = 8'd100;
        cfg_l_t = 8'd50;
        thr_q.push_back('{h: 8'd100, l: 8'd50, fm: 8'd255});
`else
        thr_q.push_back('{h: 8'd25, l: 8'd12, fm: 8'd255});
`endif
        send(8'd255, 1'b1, 1'b1, 1'b0, st);
        chk("stall_cycles", st, int'(F) + 1);
        chk("err_sof_count", err_seen, 1);
        for (int i = 0; i < 7; i++)
            send(8'(i + 1), 1'b0, 1'b1, i == 6, st);
        wait_idle();
`ifdef THRESH_OVERRIDE_EN
        cfg_override = 1'b0;
`endif

        // Partial next frame, then reset mid-frame
        for (int i = 0; i < 3; i++)
            send(8'(i + 40), i == 0, 1'b1, 1'b0, st);
        wait_idle();
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_h_t", int'(h_t), 255);
        chk("mid_rst_l_t", int'(l_t), 255);
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_frame_max", int'(frame_max), 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (F + 4) @(posedge clock);
        #1;
        chk("post_rst_s_ready", int'(s_ready), 1);
        chk("post_rst_frame_done", int'(frame_done), 0);
        chk("final_err_sof_count", err_seen, 1);
        chk("final_queue_empty", exp_q.size() + thr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
